sap_ctrl_seq: RTL and testbench
===============================

Name: sap_ctrl_seq

Overview:
- SAP-1 controller-sequencer: the source of the 14-bit control word (cw_bus) that the datapath consumes.
- Runs a 6-state one-hot ring counter (T1..T6) and decodes the IR opcode into per-T-state control bits.
- Sits between the instruction register and every datapath load/enable.
- Halts on HLT until reset.

Parameters:
CW_W, 14, control word width (fixed bit map below)
NUM_T, 6, number of T-states in the ring
CNT_W, 8, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous active-low reset
run  input  1  1 = sequencer advances; 0 = stall (state held, cw_bus forced 0)
ir_opcode  input  4  upper nibble of IR; sampled only in T4..T6
cw_bus  output  CW_W  control word, combinational decode of registered state and ir_opcode
t_state  output  NUM_T  one-hot current T-state (bit0 = T1)
halted  output  1  1 while in HALT
instr_cnt  output  CNT_W  count of completed instructions, wraps

Behaviour:
- Interface: one clock, clk. Reset is synchronous, active-low, on port reset.
- cw_bus bit map, all bits active-high:
  - 13 CP (PC increment), 12 EP (PC to bus), 11 LM (load MAR), 10 CE (RAM to bus)
  - 9 LI (load IR), 8 EI (IR address to bus), 7 LA, 6 EA, 5 SU, 4 EU
  - 3 LB, 2 LO, 1 HLT, 0 LP (load PC from bus)
- Reset (reset==0 at edge):
  - t_state=6'b000001, halted=0, instr_cnt=0.
  - cw_bus=0 combinationally while reset==0.
  - Reset mid-instruction aborts it; no count increment.
- Ring: when run=1 and not halted, t_state rotates left each edge, T6 -> T1.
- Stall: when run=0, state, counter and halted are held and cw_bus=0.
- Fetch, opcode-independent:
  - T1 = EP|LM
  - T2 = CP
  - T3 = CE|LI
- Execute (T4/T5/T6):
  - LDA 4'h0: EI|LM / CE|LA / 0
  - ADD 4'h1: EI|LM / CE|LB / EU|LA
  - SUB 4'h2: EI|LM / CE|LB / SU|EU|LA
  - OUT 4'hE: EA|LO / 0 / 0
  - HLT 4'hF: HLT in T4
  - Any other opcode: 0 in T4..T6 (NOP).
- instr_cnt: increments by 1 on the T6 -> T1 edge (run=1). Wraps 2^CNT_W-1 -> 0.
- HLT sequence:
  - In T4 with opcode 4'hF, cw_bus = HLT.
  - At the next edge with run=1, halted=1 and t_state frozen at T4.
  - While halted, cw_bus = HLT only; run is ignored; instr_cnt increments once on entry (HLT counts as completed).
  - Exit only via reset.
- Simultaneous reset==0 and any other condition: reset wins.
- t_state is always exactly one-hot. An illegal encoding (SVA-checked) recovers to T1 on the next edge.

Optional Feature:
- Macro SAP_JMP_EN.
- Defined: opcode 4'h3 = JMP, executing EI|LP in T4 and 0 in T5/T6.
- Undefined: 4'h3 decodes as NOP.
- LP (bit 0) is constant 0 when SAP_JMP_EN is undefined.

Decomposition:
- sap_pkg:
  - opcode typedef enum (LDA, ADD, SUB, JMP, OUT, HLT)
  - localparam bit indices CW_CP..CW_LP
  - T-state index constants and CW_W/NUM_T defaults
  - shared with the bench's predictor
- Sub-module sap_ring_counter:
  - parameterized one-hot ring with enable, synchronous active-low reset and freeze input
  - instantiated once

Test Plan:
- Reset held 3 cycles then released, run=1, opcode 4'h0 -> cw_bus=0 during reset; then T1 cw=0x1800, T2 0x2000, T3 0x0600, T4 0x0900, T5 0x0480, T6 0x0000; instr_cnt=1 after T6.
- Opcode 4'h2 (SUB) -> T6 cw_bus=0x00B0; opcode 4'h1 (ADD) -> T5=0x0408, T6=0x0090.
- Opcode 4'hF -> T4 cw=0x0002, halted=1 next edge; t_state stays 6'b001000 for 20 cycles with run toggling; reset then returns to T1 with halted=0.
- run=0 for 5 cycles during T3 -> t_state stays 6'b000100, cw=0; on run=1, cw resumes 0x0600.
- 256 back-to-back OUT (4'hE) instructions -> instr_cnt wraps 255 -> 0; T4 cw=0x0044.
- SAP_JMP_EN defined, opcode 4'h3 -> T4 cw=0x0101; SAP_JMP_EN undefined -> T4 cw=0x0000. Reset asserted in T5 -> next cycle T1, instr_cnt unchanged from 0.

Source files
------------

// File: rtl/sap_pkg.sv
// +----------------------------------------------------------------------------+
// | sap_pkg : shared opcodes, control-word bit map and T-state indices         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package sap_pkg;

  localparam int SAP_CW_W  = 14;
  localparam int SAP_NUM_T = 6;
  localparam int SAP_CNT_W = 8;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_JMP = 4'h3,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  localparam int CW_CP  = 13;
  localparam int CW_EP  = 12;
  localparam int CW_LM  = 11;
  localparam int CW_CE  = 10;
  localparam int CW_LI  = 9;
  localparam int CW_EI  = 8;
  localparam int CW_LA  = 7;
  localparam int CW_EA  = 6;
  localparam int CW_SU  = 5;
  localparam int CW_EU  = 4;
  localparam int CW_LB  = 3;
  localparam int CW_LO  = 2;
  localparam int CW_HLT = 1;
  localparam int CW_LP  = 0;

  localparam int T1_IDX = 0;
  localparam int T2_IDX = 1;
  localparam int T3_IDX = 2;
  localparam int T4_IDX = 3;
  localparam int T5_IDX = 4;
  localparam int T6_IDX = 5;

endpackage

`default_nettype wire

// File: rtl/sap_ctrl_seq_if.sv
// +----------------------------------------------------------------------------+
// | sap_ctrl_seq_if : run/opcode inputs and control/status outputs of the SAP  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sap_ctrl_seq_if #(
  parameter int CW_W  = 14,
  parameter int NUM_T = 6,
  parameter int CNT_W = 8
);
  logic             run;
  logic [3:0]       ir_opcode;
  logic [CW_W-1:0]  cw_bus;
  logic [NUM_T-1:0] t_state;
  logic             halted;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output run, ir_opcode,
    input  cw_bus, t_state, halted, instr_cnt
  );

  modport slave (
    input  run, ir_opcode,
    output cw_bus, t_state, halted, instr_cnt
  );
endinterface

`default_nettype wire

// File: rtl/sap_ring_counter.sv
// +----------------------------------------------------------------------------+
// | sap_ring_counter : one-hot ring with enable, freeze and illegal recovery   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sap_ring_counter #(
  parameter int NUM_T = 6
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             en_i,
  input  wire logic             freeze_i,
  output logic [NUM_T-1:0]      state_o
);

  logic [NUM_T-1:0] state_q;
  logic [NUM_T-1:0] state_d;

  always_comb begin
    state_d = state_q;
    // A corrupted (non one-hot) ring restarts the instruction at T1.
    if (!$onehot(state_q)) begin
      state_d = NUM_T'(1);
    end else if (en_i && !freeze_i) begin
      state_d = {state_q[NUM_T-2:0], state_q[NUM_T-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= NUM_T'(1);
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

  a_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot(state_q))
    else $error("ring counter state not one-hot: %b", state_q);

endmodule

`default_nettype wire

// File: rtl/sap_ctrl_seq.sv
// +----------------------------------------------------------------------------+
// | sap_ctrl_seq : SAP-1 controller-sequencer (T1..T6 ring + opcode decode)     |
// | Optional macro SAP_JMP_EN enables opcode 4'h3 = JMP (EI|LP in T4).         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sap_ctrl_seq
  import sap_pkg::*;
#(
  parameter int CW_W  = SAP_CW_W,
  parameter int NUM_T = SAP_NUM_T,
  parameter int CNT_W = SAP_CNT_W
) (
  input  wire logic     clk,
  input  wire logic     reset,
  sap_ctrl_seq_if.slave bus
);

  logic [NUM_T-1:0] t_q;
  logic             halted_q;
  logic             halted_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             hlt_entry;
  logic             instr_done;
  logic [CW_W-1:0]  cw;

  assign hlt_entry  = !halted_q && bus.run && t_q[T4_IDX] && (bus.ir_opcode == OP_HLT);
  assign instr_done = !halted_q && bus.run && t_q[T6_IDX];

  sap_ring_counter #(
    .NUM_T (NUM_T)
  ) u_ring (
    .clk      (clk),
    .reset    (reset),
    .en_i     (bus.run),
    .freeze_i (halted_q | hlt_entry),
    .state_o  (t_q)
  );

  always_comb begin
    halted_d = halted_q | hlt_entry;
    cnt_d    = cnt_q;
    // HLT counts as a completed instruction on entry.
    if (instr_done || hlt_entry) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    cw = '0;
    if (!reset) begin
      cw = '0;
    end else if (halted_q) begin
      cw[CW_HLT] = 1'b1;
    end else if (!bus.run) begin
      cw = '0;
    end else if (t_q[T1_IDX]) begin
      cw[CW_EP] = 1'b1;
      cw[CW_LM] = 1'b1;
    end else if (t_q[T2_IDX]) begin
      cw[CW_CP] = 1'b1;
    end else if (t_q[T3_IDX]) begin
      cw[CW_CE] = 1'b1;
      cw[CW_LI] = 1'b1;
    end else begin
      case (bus.ir_opcode)
        OP_LDA, OP_ADD, OP_SUB: begin
          if (t_q[T4_IDX]) begin
            cw[CW_EI] = 1'b1;
            cw[CW_LM] = 1'b1;
          end else if (t_q[T5_IDX]) begin
            cw[CW_CE] = 1'b1;
            if (bus.ir_opcode == OP_LDA) cw[CW_LA] = 1'b1;
            else                         cw[CW_LB] = 1'b1;
          end else if (t_q[T6_IDX] && bus.ir_opcode != OP_LDA) begin
            cw[CW_EU] = 1'b1;
            cw[CW_LA] = 1'b1;
            cw[CW_SU] = (bus.ir_opcode == OP_SUB);
          end
        end
        OP_OUT: begin
          if (t_q[T4_IDX]) begin
            cw[CW_EA] = 1'b1;
            cw[CW_LO] = 1'b1;
          end
        end
        OP_HLT: begin
          if (t_q[T4_IDX]) cw[CW_HLT] = 1'b1;
        end
`ifdef SAP_JMP_EN
        OP_JMP: begin
          if (t_q[T4_IDX]) begin
            cw[CW_EI] = 1'b1;
            cw[CW_LP] = 1'b1;
          end
        end
`endif
        default: cw = '0;
      endcase
    end
  end

  assign bus.cw_bus    = cw;
  assign bus.t_state   = t_q;
  assign bus.halted    = halted_q;
  assign bus.instr_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sap_ctrl_seq.sv
// +----------------------------------------------------------------------------+
// | tb_sap_ctrl_seq : scoreboard bench with an instruction-level step model    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sap_ctrl_seq;
  import sap_pkg::*;

  typedef struct packed {
    logic [13:0] cw;
    logic [5:0]  t;
    logic        h;
    logic [7:0]  cnt;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: instruction step number 1..6, halt flag, retired count.
  int       m_step;
  logic     m_halted;
  int       m_cnt;

  sap_ctrl_seq_if #(.CW_W(14), .NUM_T(6), .CNT_W(8)) bus ();

  sap_ctrl_seq #(.CW_W(14), .NUM_T(6), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] exp_cw(int step, logic [3:0] op, logic rn, logic rr, logic h);
    logic [13:0] ex [3];
    if (!rn) return 14'h0000;
    if (h)   return 14'h0002;
    if (!rr) return 14'h0000;
    if (step == 1) return 14'h1800;
    if (step == 2) return 14'h2000;
    if (step == 3) return 14'h0600;
    case (op)
      4'h0:    ex = '{14'h0900, 14'h0480, 14'h0000};
      4'h1:    ex = '{14'h0900, 14'h0408, 14'h0090};
      4'h2:    ex = '{14'h0900, 14'h0408, 14'h00B0};
      4'hE:    ex = '{14'h0044, 14'h0000, 14'h0000};
      4'hF:    ex = '{14'h0002, 14'h0000, 14'h0000};
`ifdef SAP_JMP_EN
      4'h3:    ex = '{14'h0101, 14'h0000, 14'h0000};
`endif
      default: ex = '{14'h0000, 14'h0000, 14'h0000};
    endcase
    return ex[step-4];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  // One clock of stimulus: drive, predict this cycle's outputs, advance model.
  task automatic cycle(input logic rn, input logic rr, input logic [3:0] op);
    exp_t e;
    reset         = rn;
    bus.run       = rr;
    bus.ir_opcode = op;
    e.cw  = exp_cw(m_step, op, rn, rr, m_halted);
    e.t   = 6'(1 << (m_step - 1));
    e.h   = m_halted;
    e.cnt = 8'(m_cnt);
    exp_q.push_back(e);
    if (!rn) begin
      m_step = 1; m_halted = 1'b0; m_cnt = 0;
    end else if (!m_halted && rr) begin
      if (m_step == 4 && op == 4'hF) begin
        m_halted = 1'b1;
        m_cnt    = (m_cnt + 1) % 256;
      end else if (m_step == 6) begin
        m_step = 1;
        m_cnt  = (m_cnt + 1) % 256;
      end else begin
        m_step++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [3:0] op);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, op);
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("cw_bus",    32'(bus.cw_bus),    32'(mon_e.cw));
        chk("t_state",   32'(bus.t_state),   32'(mon_e.t));
        chk("halted",    32'(bus.halted),    32'(mon_e.h));
        chk("instr_cnt", 32'(bus.instr_cnt), 32'(mon_e.cnt));
      end
    end
  end

  initial begin
    reset         = 1'b0;
    bus.run       = 1'b0;
    bus.ir_opcode = 4'h0;
    @(posedge clk);
    #1;
    m_step = 1; m_halted = 1'b0; m_cnt = 0;

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'h0);
    instr(4'h0);
    instr(4'h2);
    instr(4'h1);
    instr(4'hE);
    instr(4'h3);
    instr(4'h7);

    // Stall in T3 for five cycles, then resume.
    cycle(1'b1, 1'b1, 4'h0);
    cycle(1'b1, 1'b1, 4'h0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 4'h0);

    // Randomised run/opcode/reset traffic without HLT.
    for (int i = 0; i < 400; i++)
      cycle(1'(($urandom_range(0, 49) != 0)), 1'(($urandom_range(0, 6) != 0)),
            4'($urandom_range(0, 14)));

    // Counter wrap across 256 OUT instructions.
    cycle(1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 257; i++) instr(4'hE);

    // Reset asserted in T5 aborts the instruction without counting it.
    cycle(1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 4'h0);
    cycle(1'b0, 1'b1, 4'h0);
    instr(4'h1);

    // HLT: freeze at T4 regardless of run, exit only through reset.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 4'hF);
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 1'(i % 2), 4'($urandom_range(0, 15)));
    cycle(1'b0, 1'b1, 4'h0);
    instr(4'h0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
